// File: rtl/dram_slot_seq.sv
// DRAM slot sequencer: splits each 500 ns memory cycle (16 clk32) into a refresh/video
// slot A and a CPU slot B, driving RAS/CAS/WE, the muxed row/column address and acks.
module dram_slot_seq #(
  parameter int AW         = 20,
  parameter int REF_PERIOD = 32
) (
  input  logic              clk32,
  input  logic              res,
  input  logic              m2clock_en_p,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic              vid_req,
  input  logic [AW-1:0]     vid_addr,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [AW/2-1:0]   ram_a,
  output logic              cpu_dtack,
  output logic              vid_ack,
  output logic              refresh_act
);

  localparam int HW = AW / 2;
  localparam int DW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_REFRESH,
    OWN_VIDEO,
    OWN_CPU
  } owner_t;

  logic [3:0]    ph, ph_nxt;
  logic          synced, synced_nxt;
  owner_t        owner_a, owner_a_nxt;
  owner_t        owner_b, owner_b_nxt;
  logic [AW-1:0] addr_a, addr_a_nxt;
  logic [AW-1:0] addr_b, addr_b_nxt;
  logic          we_b, we_b_nxt;
  logic [DW-1:0] ref_div, ref_div_nxt;
  logic [HW-1:0] ref_row, ref_row_nxt;
  logic          ref_pend, ref_pend_nxt;

  owner_t        act_owner;
  logic [AW-1:0] act_addr;
  logic [2:0]    ofs;
  logic [HW-1:0] slot_row;
  logic          ras_n_nxt, cas_n_nxt, we_n_nxt;
  logic [HW-1:0] ram_a_nxt;
  logic          cpu_dtack_nxt, vid_ack_nxt, refresh_act_nxt;

  // Phase tracking, slot ownership and refresh bookkeeping. A strobe that arrives
  // anywhere but ph=15 is a resync: both owners drop to IDLE, which aborts the slot.
  always_comb begin
    ph_nxt       = m2clock_en_p ? 4'd0 : ph + 4'd1;
    synced_nxt   = synced | m2clock_en_p;
    owner_a_nxt  = owner_a;
    owner_b_nxt  = owner_b;
    addr_a_nxt   = (ph == 4'd0) ? vid_addr : addr_a;
    addr_b_nxt   = (ph == 4'd8) ? cpu_addr : addr_b;
    we_b_nxt     = (ph == 4'd8) ? cpu_we : we_b;
    ref_div_nxt  = ref_div;
    ref_row_nxt  = ref_row;
    ref_pend_nxt = ref_pend;

    if (m2clock_en_p) begin
      owner_a_nxt = OWN_IDLE;
    end else if (ph == 4'd0) begin
      if (!synced)       owner_a_nxt = OWN_IDLE;
      else if (ref_pend) owner_a_nxt = OWN_REFRESH;
      else if (vid_req)  owner_a_nxt = OWN_VIDEO;
      else               owner_a_nxt = OWN_IDLE;
    end else if (ph == 4'd7) begin
      owner_a_nxt = OWN_IDLE;
    end

    if (m2clock_en_p) begin
      owner_b_nxt = OWN_IDLE;
    end else if (ph == 4'd8) begin
      owner_b_nxt = (synced && cpu_req) ? OWN_CPU : OWN_IDLE;
    end else if (ph == 4'd15) begin
      owner_b_nxt = OWN_IDLE;
    end

    if (synced && ph == 4'd0) begin
      if (ref_div == DW'(REF_PERIOD - 1)) begin
        ref_div_nxt  = '0;
        ref_pend_nxt = 1'b1;
      end else begin
        ref_div_nxt = ref_div + DW'(1);
      end
    end

    // Only a refresh slot that runs to completion retires the pending request.
    if (ph == 4'd7 && owner_a == OWN_REFRESH && !m2clock_en_p) begin
      ref_pend_nxt = 1'b0;
      ref_row_nxt  = ref_row + HW'(1);
    end
  end

  // Outputs are decoded from the upcoming phase and owner so that the registered
  // pins line up with the phase the counter holds in the same cycle.
  always_comb begin
    act_owner       = ph_nxt[3] ? owner_b_nxt : owner_a_nxt;
    act_addr        = ph_nxt[3] ? addr_b_nxt : addr_a_nxt;
    ofs             = ph_nxt[2:0];
    slot_row        = (act_owner == OWN_REFRESH) ? ref_row : act_addr[HW-1:0];
    ras_n_nxt       = 1'b1;
    cas_n_nxt       = 1'b1;
    we_n_nxt        = 1'b1;
    ram_a_nxt       = ram_a;
    cpu_dtack_nxt   = 1'b0;
    vid_ack_nxt     = 1'b0;
    refresh_act_nxt = 1'b0;

    if (act_owner != OWN_IDLE) begin
      if (ofs >= 3'd1 && ofs <= 3'd3)
        ram_a_nxt = slot_row;
      else if (ofs >= 3'd4 && act_owner != OWN_REFRESH)
        ram_a_nxt = act_addr[AW-1:HW];
      ras_n_nxt       = !(ofs >= 3'd2 && ofs <= 3'd6);
      cas_n_nxt       = !(ofs >= 3'd4 && ofs <= 3'd6 && act_owner != OWN_REFRESH);
      we_n_nxt        = !(ofs >= 3'd3 && ofs <= 3'd6 && act_owner == OWN_CPU && we_b_nxt);
      vid_ack_nxt     = (act_owner == OWN_VIDEO) && (ph_nxt == 4'd6);
      cpu_dtack_nxt   = (act_owner == OWN_CPU) && (ph_nxt == 4'd14);
      refresh_act_nxt = (act_owner == OWN_REFRESH);
    end
  end

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      ph       <= 4'd0;
      synced   <= 1'b0;
      owner_a  <= OWN_IDLE;
      owner_b  <= OWN_IDLE;
      addr_a   <= '0;
      addr_b   <= '0;
      we_b     <= 1'b0;
      ref_div  <= '0;
      ref_row  <= '0;
      ref_pend <= 1'b0;
    end else begin
      ph       <= ph_nxt;
      synced   <= synced_nxt;
      owner_a  <= owner_a_nxt;
      owner_b  <= owner_b_nxt;
      addr_a   <= addr_a_nxt;
      addr_b   <= addr_b_nxt;
      we_b     <= we_b_nxt;
      ref_div  <= ref_div_nxt;
      ref_row  <= ref_row_nxt;
      ref_pend <= ref_pend_nxt;
    end
  end

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      ras_n       <= 1'b1;
      cas_n       <= 1'b1;
      we_n        <= 1'b1;
      ram_a       <= '0;
      cpu_dtack   <= 1'b0;
      vid_ack     <= 1'b0;
      refresh_act <= 1'b0;
    end else begin
      ras_n       <= ras_n_nxt;
      cas_n       <= cas_n_nxt;
      we_n        <= we_n_nxt;
      ram_a       <= ram_a_nxt;
      cpu_dtack   <= cpu_dtack_nxt;
      vid_ack     <= vid_ack_nxt;
      refresh_act <= refresh_act_nxt;
    end
  end

endmodule

// File: tb/tb_dram_slot_seq.sv
// Directed bench for dram_slot_seq: refresh cadence, CPU read/write, video vs refresh,
// resync abort and asynchronous reset in the middle of a slot.
`timescale 1ns/1ps
module tb_dram_slot_seq;
  localparam int AW = 20;
  localparam int HW = AW / 2;

  logic          clk32 = 1'b0;
  logic          res = 1'b1;
  logic          m2clock_en_p = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0, vid_addr = '0;
  logic          ras_n, cas_n, we_n, cpu_dtack, vid_ack, refresh_act;
  logic [HW-1:0] ram_a;

  int total = 0;
  int bad = 0;
  int exp_ph = 0;
  bit auto_sync = 1'b0;
  bit inject = 1'b0;

  logic          s_ras[16], s_cas[16], s_we[16], s_dtk[16], s_vak[16], s_ref[16];
  logic [HW-1:0] s_ram[16];

  dram_slot_seq #(.AW(AW), .REF_PERIOD(32)) dut (
    .clk32(clk32), .res(res), .m2clock_en_p(m2clock_en_p),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ram_a(ram_a),
    .cpu_dtack(cpu_dtack), .vid_ack(vid_ack), .refresh_act(refresh_act)
  );

  always #16 clk32 = ~clk32;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // One clk32; the strobe is driven during ph=15 when auto_sync is on, or on demand.
  task automatic step();
    m2clock_en_p = inject || (auto_sync && exp_ph == 15);
    @(posedge clk32);
    #1;
    if (res) exp_ph = 0;
    else     exp_ph = m2clock_en_p ? 0 : (exp_ph + 1) % 16;
    inject = 1'b0;
    m2clock_en_p = 1'b0;
  endtask

  task automatic goto_ph0();
    int n = 0;
    do begin
      step();
      n++;
    end while (exp_ph != 0 && n < 64);
    total++;
    if (exp_ph != 0) begin
      bad++;
      $display("[TB] FAIL goto_ph0 got ph=%0d want 0", exp_ph);
    end
  endtask

  // Records one memory cycle (ph 0..15) starting at ph=0; requests can be dropped mid-cycle.
  task automatic capture(input int drop_cpu, input int drop_vid);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      s_ras[k] = ras_n; s_cas[k] = cas_n; s_we[k] = we_n; s_ram[k] = ram_a;
      s_dtk[k] = cpu_dtack; s_vak[k] = vid_ack; s_ref[k] = refresh_act;
      if (k == drop_cpu) cpu_req = 1'b0;
      if (k == drop_vid) vid_req = 1'b0;
    end
    step();
  endtask

  task automatic test_reset();
    step(); step();
    total += 7;
    if (ras_n !== 1'b1)     begin bad++; $display("[TB] FAIL rst_ras got=%b want=1", ras_n); end
    if (cas_n !== 1'b1)     begin bad++; $display("[TB] FAIL rst_cas got=%b want=1", cas_n); end
    if (we_n !== 1'b1)      begin bad++; $display("[TB] FAIL rst_we got=%b want=1", we_n); end
    if (ram_a !== '0)       begin bad++; $display("[TB] FAIL rst_ram_a got=%h want=0", ram_a); end
    if (cpu_dtack !== 1'b0) begin bad++; $display("[TB] FAIL rst_dtack got=%b want=0", cpu_dtack); end
    if (vid_ack !== 1'b0)   begin bad++; $display("[TB] FAIL rst_vack got=%b want=0", vid_ack); end
    if (refresh_act !== 1'b0) begin bad++; $display("[TB] FAIL rst_ref got=%b want=0", refresh_act); end
    res = 1'b0;
  endtask

  task automatic test_idle_refresh();
    logic e;
    auto_sync = 1'b1;
    goto_ph0();
    for (int c = 1; c <= 32; c++) begin
      capture(16, 16);
      for (int k = 0; k < 16; k++) begin
        total++;
        if (s_ras[k] !== 1'b1 || s_cas[k] !== 1'b1 || s_we[k] !== 1'b1 || s_ref[k] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL idle c=%0d ph=%0d got ras=%b cas=%b we=%b ref=%b want 1110", c, k, s_ras[k], s_cas[k], s_we[k], s_ref[k]);
        end
      end
    end
    capture(16, 16);
    for (int k = 0; k < 16; k++) begin
      e = !(k >= 2 && k <= 6);
      total += 3;
      if (s_ras[k] !== e)    begin bad++; $display("[TB] FAIL ref0_ras ph=%0d got=%b want=%b", k, s_ras[k], e); end
      if (s_cas[k] !== 1'b1) begin bad++; $display("[TB] FAIL ref0_cas ph=%0d got=%b want=1", k, s_cas[k]); end
      e = (k >= 1 && k <= 7);
      if (s_ref[k] !== e)    begin bad++; $display("[TB] FAIL ref0_act ph=%0d got=%b want=%b", k, s_ref[k], e); end
      if (k >= 1 && k <= 3) begin
        total++;
        if (s_ram[k] !== 10'h000) begin bad++; $display("[TB] FAIL ref0_row ph=%0d got=%h want=000", k, s_ram[k]); end
      end
    end
  endtask

  task automatic test_cpu_access(input logic wr, input int drop);
    logic e;
    cpu_req = 1'b1; cpu_we = wr; cpu_addr = 20'h3A5C7;
    capture(drop, 16);
    for (int k = 0; k < 16; k++) begin
      total += 6;
      e = !(k >= 10 && k <= 14);
      if (s_ras[k] !== e) begin bad++; $display("[TB] FAIL cpu_ras we=%b ph=%0d got=%b want=%b", wr, k, s_ras[k], e); end
      e = !(k >= 12 && k <= 14);
      if (s_cas[k] !== e) begin bad++; $display("[TB] FAIL cpu_cas we=%b ph=%0d got=%b want=%b", wr, k, s_cas[k], e); end
      e = !(wr && k >= 11 && k <= 14);
      if (s_we[k] !== e)  begin bad++; $display("[TB] FAIL cpu_we we=%b ph=%0d got=%b want=%b", wr, k, s_we[k], e); end
      e = (k == 14);
      if (s_dtk[k] !== e) begin bad++; $display("[TB] FAIL cpu_dtack we=%b ph=%0d got=%b want=%b", wr, k, s_dtk[k], e); end
      if (s_vak[k] !== 1'b0) begin bad++; $display("[TB] FAIL cpu_vack ph=%0d got=%b want=0", k, s_vak[k]); end
      if (s_ref[k] !== 1'b0) begin bad++; $display("[TB] FAIL cpu_ref ph=%0d got=%b want=0", k, s_ref[k]); end
      if (k >= 9) begin
        total++;
        if (s_ram[k] !== ((k <= 11) ? 10'h1C7 : 10'h0E9))
          begin bad++; $display("[TB] FAIL cpu_ram_a ph=%0d got=%h want=%h", k, s_ram[k], (k <= 11) ? 10'h1C7 : 10'h0E9); end
      end
    end
  endtask

  task automatic test_cpu_released();
    capture(16, 16);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (s_dtk[k] !== 1'b0 || s_ras[k] !== 1'b1)
        begin bad++; $display("[TB] FAIL cpu_released ph=%0d got dtack=%b ras=%b want 0/1", k, s_dtk[k], s_ras[k]); end
    end
  endtask

  task automatic test_video_vs_refresh();
    logic e;
    repeat (28) capture(16, 16);
    vid_req = 1'b1; vid_addr = 20'h12345;
    capture(16, 16);
    for (int k = 0; k < 16; k++) begin
      total += 3;
      e = (k >= 1 && k <= 7);
      if (s_ref[k] !== e)    begin bad++; $display("[TB] FAIL vr_ref ph=%0d got=%b want=%b", k, s_ref[k], e); end
      if (s_cas[k] !== 1'b1) begin bad++; $display("[TB] FAIL vr_cas ph=%0d got=%b want=1", k, s_cas[k]); end
      if (s_vak[k] !== 1'b0) begin bad++; $display("[TB] FAIL vr_vack ph=%0d got=%b want=0", k, s_vak[k]); end
      if (k >= 1 && k <= 3) begin
        total++;
        if (s_ram[k] !== 10'h001) begin bad++; $display("[TB] FAIL ref1_row ph=%0d got=%h want=001", k, s_ram[k]); end
      end
    end
    capture(16, 3);
    for (int k = 0; k < 16; k++) begin
      total += 4;
      e = (k == 6);
      if (s_vak[k] !== e) begin bad++; $display("[TB] FAIL vid_ack ph=%0d got=%b want=%b", k, s_vak[k], e); end
      e = !(k >= 2 && k <= 6);
      if (s_ras[k] !== e) begin bad++; $display("[TB] FAIL vid_ras ph=%0d got=%b want=%b", k, s_ras[k], e); end
      e = !(k >= 4 && k <= 6);
      if (s_cas[k] !== e) begin bad++; $display("[TB] FAIL vid_cas ph=%0d got=%b want=%b", k, s_cas[k], e); end
      if (s_ref[k] !== 1'b0) begin bad++; $display("[TB] FAIL vid_ref ph=%0d got=%b want=0", k, s_ref[k]); end
      if (k >= 1 && k <= 7) begin
        total++;
        if (s_ram[k] !== ((k <= 3) ? 10'h345 : 10'h048))
          begin bad++; $display("[TB] FAIL vid_ram_a ph=%0d got=%h want=%h", k, s_ram[k], (k <= 3) ? 10'h345 : 10'h048); end
      end
    end
  endtask

  task automatic test_resync_abort();
    logic e;
    bit saw_dtack = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h0F00F;
    while (exp_ph != 11) step();
    total += 2;
    if (ras_n !== 1'b0) begin bad++; $display("[TB] FAIL abort_pre_ras got=%b want=0", ras_n); end
    if (we_n !== 1'b0)  begin bad++; $display("[TB] FAIL abort_pre_we got=%b want=0", we_n); end
    inject = 1'b1; cpu_req = 1'b0; vid_req = 1'b1;
    step();
    total += 4;
    if (ras_n !== 1'b1)     begin bad++; $display("[TB] FAIL abort_ras got=%b want=1", ras_n); end
    if (cas_n !== 1'b1)     begin bad++; $display("[TB] FAIL abort_cas got=%b want=1", cas_n); end
    if (we_n !== 1'b1)      begin bad++; $display("[TB] FAIL abort_we got=%b want=1", we_n); end
    if (cpu_dtack !== 1'b0) begin bad++; $display("[TB] FAIL abort_dtack got=%b want=0", cpu_dtack); end
    for (int n = 0; n < 16; n++) begin
      step();
      if (cpu_dtack) saw_dtack = 1'b1;
      e = (exp_ph == 6);
      total++;
      if (vid_ack !== e) begin bad++; $display("[TB] FAIL abort_restart_vack ph=%0d got=%b want=%b", exp_ph, vid_ack, e); end
      if (exp_ph == 6) vid_req = 1'b0;
    end
    total++;
    if (saw_dtack) begin bad++; $display("[TB] FAIL abort_no_dtack got=1 want=0"); end
  endtask

  task automatic test_reset_midslot();
    logic e;
    bit saw = 1'b0;
    vid_req = 1'b1; vid_addr = 20'h0ABCD;
    while (exp_ph != 5) step();
    total++;
    if (ras_n !== 1'b0) begin bad++; $display("[TB] FAIL rmid_pre_ras got=%b want=0", ras_n); end
    #5 res = 1'b1;
    #1;
    total += 4;
    if (ras_n !== 1'b1 || cas_n !== 1'b1 || we_n !== 1'b1)
      begin bad++; $display("[TB] FAIL rmid_strobes got=%b%b%b want=111", ras_n, cas_n, we_n); end
    if (ram_a !== '0) begin bad++; $display("[TB] FAIL rmid_ram_a got=%h want=0", ram_a); end
    if (vid_ack !== 1'b0 || cpu_dtack !== 1'b0)
      begin bad++; $display("[TB] FAIL rmid_acks got=%b%b want=00", vid_ack, cpu_dtack); end
    if (refresh_act !== 1'b0) begin bad++; $display("[TB] FAIL rmid_ref got=%b want=0", refresh_act); end
    auto_sync = 1'b0;
    step();
    res = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (ras_n !== 1'b1 || vid_ack !== 1'b0) saw = 1'b1;
    end
    total++;
    if (saw) begin bad++; $display("[TB] FAIL rmid_unsynced_grant got=1 want=0"); end
    auto_sync = 1'b1;
    goto_ph0();
    capture(16, 7);
    for (int k = 0; k < 16; k++) begin
      total += 2;
      e = (k == 6);
      if (s_vak[k] !== e) begin bad++; $display("[TB] FAIL rmid_vack ph=%0d got=%b want=%b", k, s_vak[k], e); end
      e = !(k >= 2 && k <= 6);
      if (s_ras[k] !== e) begin bad++; $display("[TB] FAIL rmid_ras ph=%0d got=%b want=%b", k, s_ras[k], e); end
    end
    total += 2;
    if (s_ram[1] !== 10'h3CD) begin bad++; $display("[TB] FAIL rmid_row got=%h want=3CD", s_ram[1]); end
    if (s_ram[4] !== 10'h02A) begin bad++; $display("[TB] FAIL rmid_col got=%h want=02A", s_ram[4]); end
  endtask

  initial begin
    test_reset();
    test_idle_refresh();
    test_cpu_access(1'b0, 16);
    test_cpu_access(1'b1, 10);
    test_cpu_released();
    test_video_vs_refresh();
    test_resync_abort();
    test_reset_midslot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_slot_seq.md
Name: dram_slot_seq

Overview:
- DRAM slot sequencer fed directly by the clock generator's 2 MHz cycle strobe (m2clock_en_p).
- Runs a 16-clk32 phase counter aligned to that strobe and splits each 500 ns memory cycle into two 250 ns slots: slot A (refresh/video) and slot B (CPU).
- Produces RAS/CAS/WE, the multiplexed row/column address, and per-slot acknowledge strobes.
- Sits between clock generation and the DRAM pins / shifter / CPU bus interface.

Parameters:
AW, 20, word address width (even); ram_a width is AW/2.
REF_PERIOD, 32, memory cycles between refresh requests (16 us at 2 MHz).

Ports:
clk32  in  1  32 MHz system clock
res  in  1  asynchronous active-high reset
m2clock_en_p  in  1  one-clk32 pulse marking memory-cycle start (from clock generator)
cpu_req  in  1  CPU access request, level
cpu_we  in  1  CPU write when 1
cpu_addr  in  AW  CPU word address
vid_req  in  1  shifter fetch request, level
vid_addr  in  AW  video word address
ras_n  out  1  DRAM RAS, active low
cas_n  out  1  DRAM CAS, active low
we_n  out  1  DRAM write enable, active low
ram_a  out  AW/2  multiplexed DRAM address
cpu_dtack  out  1  one-clk32 pulse, CPU access done / data latch
vid_ack  out  1  one-clk32 pulse, video data valid
refresh_act  out  1  high while a refresh slot is active

Behaviour:
- Reset (async, immediate), all values held while res=1:
  - ph=0, synced=0, owner_a=owner_b=IDLE.
  - ras_n=cas_n=we_n=1, ram_a=0, cpu_dtack=vid_ack=refresh_act=0.
  - Refresh divider=0, ref_row=0, ref_pend=0.
- Phase counter ph[3:0]:
  - Next value is 0 if m2clock_en_p=1, else ph+1 (wraps 15->0).
  - synced is set on the first m2clock_en_p after reset. No slot is granted while synced=0.
- All outputs are registered. "At ph=k" below means the output value during the clk32 cycle in which the counter holds k.
- Slot A arbitration:
  - Sampled in the cycle ph=0. Owner is held for ph 1..7.
  - Priority: REFRESH if ref_pend, else VIDEO if vid_req, else IDLE.
- Slot B arbitration:
  - Sampled in the cycle ph=8. Owner is held for ph 9..15.
  - CPU if cpu_req, else IDLE.
  - cpu_addr and cpu_we are captured at ph=8. vid_addr is captured at ph=0.
- Slot A, offset o = ph; slot B, o = ph-8; non-IDLE owner:
  - ram_a = row (captured addr[AW/2-1:0], or ref_row for refresh) at o=1..3.
  - ram_a = column (addr[AW-1:AW/2]) at o=4..7.
  - ras_n=0 at o=2..6.
  - cas_n=0 at o=4..6, except refresh, which is RAS-only and keeps cas_n=1.
  - we_n=0 at o=3..6 only for a CPU write.
  - vid_ack=1 at ph=6 for a VIDEO slot.
  - cpu_dtack=1 at ph=14 for a CPU slot.
  - refresh_act=1 at ph=1..7 for a REFRESH slot.
- IDLE slot: strobes inactive, ram_a holds its last value.
- Request deasserted mid-slot: the slot completes normally and the ack is still pulsed. A requester holding req over its ack gets the next slot of its type.
- Refresh:
  - The divider increments once per memory cycle, at ph=0 while synced.
  - At REF_PERIOD-1 it wraps to 0 and sets ref_pend. A wrap while ref_pend is already 1 is lost; no counting.
  - ref_pend clears and ref_row increments, wrapping at 2^(AW/2), at the end of a refresh slot (transition ph 7->8).
- Resync abort: m2clock_en_p asserted when ph != 15 restarts the counter at 0.
  - Any slot in progress is aborted: strobes go inactive next cycle and no ack is pulsed.
  - An aborted refresh leaves ref_pend=1 and ref_row unchanged.
  - Arbitration restarts at ph=0.
- Ack timing: dtack/ack are never asserted outside the stated phases. At most one pulse per slot.

Test Plan:
- Reset then a steady m2clock_en_p every 16 clk32 with no requests -> ras_n/cas_n/we_n stay 1. First refresh_act pulse (ph 1..7) appears in the cycle after 32 memory cycles. ram_a row=0 at ph1..3, then ref_row=1.
- cpu_req=1, cpu_we=0, cpu_addr=0x3A5C7 -> ras_n low at ph 10..14, cas_n low at ph 12..14. ram_a=0x1C7 at ph 9..11, then 0x0E9 at ph 12..15. cpu_dtack only at ph14. we_n stays 1.
- Same CPU access with cpu_we=1 -> we_n low at ph 11..14.
- vid_req=1 while ref_pend=1 -> slot A is refresh (cas_n=1, no vid_ack). The next cycle serves video, with vid_ack at ph6.
- m2clock_en_p injected at ph=11 during a CPU write -> ras_n/cas_n/we_n return to 1 next cycle, no cpu_dtack, ph=0 follows.
- res asserted at ph=5 of a video slot -> all outputs go inactive immediately. No slot is granted until the first m2clock_en_p after release.
